// File: rtl/mmio_uart_tx_pkg.sv
// Shared definitions for the memory-mapped UART transmitter:
// FSM encodings, register offsets and STATUS bit positions.
package mmio_uart_tx_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } txStateT;

  localparam logic [31:0] TXDATA_OFS = 32'h0000_0000;
  localparam logic [31:0] STATUS_OFS = 32'h0000_0004;

  localparam int ST_FULL      = 0;
  localparam int ST_EMPTY     = 1;
  localparam int ST_ACTIVE    = 2;
  localparam int ST_OVF       = 3;
  localparam int ST_COUNT_LO  = 4;
  localparam int ST_PARITY_EN = 8;

  function automatic logic evenParity(input logic [7:0] b);
    return ^b;
  endfunction

endpackage

// File: rtl/mmio_uart_tx_fifo.sv
// Synchronous byte FIFO, depth 2**AW. A push while full is accepted only
// when a pop happens in the same cycle (the freed slot is reused).
module mmio_uart_tx_fifo #(
  parameter int AW = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        push,
  input  logic        pop,
  input  logic [7:0]  din,
  output logic [7:0]  dout,
  output logic        full,
  output logic        empty,
  output logic [AW:0] count
);
  localparam int DEPTH = 1 << AW;

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wrPtr;
  logic [AW-1:0] rdPtr;
  logic          doPush;
  logic          doPop;

  // count never exceeds DEPTH, so its top bit alone marks full
  assign full   = count[AW];
  assign empty  = (count == '0);
  assign dout   = mem[rdPtr];
  assign doPop  = pop && !empty;
  assign doPush = push && (!full || doPop);

  always_ff @(posedge clk) begin
    if (doPush) mem[wrPtr] <= din;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wrPtr <= '0;
      rdPtr <= '0;
      count <= '0;
    end else begin
      if (doPush) wrPtr <= wrPtr + AW'(1);
      if (doPop)  rdPtr <= rdPtr + AW'(1);
      case ({doPush, doPop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/mmio_uart_tx.sv
// Memory-mapped UART transmitter: TXDATA/STATUS decode, byte FIFO and 8N1 serialiser.
// Build option: define UART_TX_PARITY_EN to add an even-parity bit after the data bits.
module mmio_uart_tx
  import mmio_uart_tx_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR    = 32'hFFFF_0000,
  parameter int          CLKS_PER_BIT = 16,
  parameter int          FIFO_AW      = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        we,
  input  logic [31:0] a,
  input  logic [31:0] wd,
  output logic [31:0] rd,
  output logic        hit,
  output logic        tx,
  output logic        busy
);
  localparam int                BAUD_W    = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);

  logic selTx;
  logic selStatus;
  logic wrTx;
  logic wrStatus;
  logic overflow;
  logic [31:0] status;

  logic             fifoPop;
  logic             fifoFull;
  logic             fifoEmpty;
  logic [7:0]       fifoDout;
  logic [FIFO_AW:0] fifoCount;

  txStateT           state;
  txStateT           stateNext;
  logic [BAUD_W-1:0] baudCnt;
  logic [BAUD_W-1:0] baudNext;
  logic              baudDone;
  logic [2:0]        bitIdx;
  logic [2:0]        bitNext;
  logic [7:0]        shiftReg;
  logic [7:0]        shiftNext;
  logic              txNext;
`ifdef UART_TX_PARITY_EN
  logic              parityBit;
  logic              parityNext;
`endif

  logic unusedWd;
  assign unusedWd = ^wd[31:8];

  assign selTx     = (a == BASE_ADDR + TXDATA_OFS);
  assign selStatus = (a == BASE_ADDR + STATUS_OFS);
  assign wrTx      = we && selTx;
  assign wrStatus  = we && selStatus;
  assign hit       = selTx || selStatus;
  assign busy      = (state != IDLE) || !fifoEmpty;

  mmio_uart_tx_fifo #(.AW(FIFO_AW)) uFifo (
    .clk   (clk),
    .reset (reset),
    .push  (wrTx),
    .pop   (fifoPop),
    .din   (wd[7:0]),
    .dout  (fifoDout),
    .full  (fifoFull),
    .empty (fifoEmpty),
    .count (fifoCount)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      overflow <= 1'b0;
    end else if (wrTx && fifoFull && !fifoPop) begin
      overflow <= 1'b1;
    end else if (wrStatus && wd[ST_OVF]) begin
      overflow <= 1'b0;
    end
  end

  always_comb begin
    status                      = '0;
    status[ST_FULL]             = fifoFull;
    status[ST_EMPTY]            = fifoEmpty;
    status[ST_ACTIVE]           = (state != IDLE);
    status[ST_OVF]              = overflow;
    status[ST_COUNT_LO +: 4]    = 4'(fifoCount);
`ifdef UART_TX_PARITY_EN
    status[ST_PARITY_EN]        = 1'b1;
`else
    status[ST_PARITY_EN]        = 1'b0;
`endif
    rd = selStatus ? status : 32'h0;
  end

  // state | meaning: IDLE line high, wait for FIFO | START start bit | DATA 8 bits LSB first | PARITY even parity | STOP stop bit
  assign baudDone = (baudCnt == BAUD_LAST);

  always_comb begin
    stateNext = state;
    baudNext  = baudCnt;
    bitNext   = bitIdx;
    shiftNext = shiftReg;
    fifoPop   = 1'b0;
`ifdef UART_TX_PARITY_EN
    parityNext = parityBit;
`endif
    case (state)
      IDLE: begin
        baudNext = '0;
        if (!fifoEmpty) begin
          fifoPop   = 1'b1;
          shiftNext = fifoDout;
          stateNext = START;
`ifdef UART_TX_PARITY_EN
          parityNext = evenParity(fifoDout);
`endif
        end
      end
      START: begin
        if (baudDone) begin
          baudNext  = '0;
          stateNext = DATA;
        end else begin
          baudNext = baudCnt + BAUD_W'(1);
        end
      end
      DATA: begin
        if (baudDone) begin
          baudNext  = '0;
          shiftNext = {1'b0, shiftReg[7:1]};
          if (bitIdx == 3'd7) begin
            bitNext = 3'd0;
`ifdef UART_TX_PARITY_EN
            stateNext = PARITY;
`else
            stateNext = STOP;
`endif
          end else begin
            bitNext = bitIdx + 3'd1;
          end
        end else begin
          baudNext = baudCnt + BAUD_W'(1);
        end
      end
`ifdef UART_TX_PARITY_EN
      PARITY: begin
        if (baudDone) begin
          baudNext  = '0;
          stateNext = STOP;
        end else begin
          baudNext = baudCnt + BAUD_W'(1);
        end
      end
`endif
      STOP: begin
        if (baudDone) begin
          baudNext = '0;
          // chain the next frame without an idle cycle when data is waiting
          if (!fifoEmpty) begin
            fifoPop   = 1'b1;
            shiftNext = fifoDout;
            stateNext = START;
`ifdef UART_TX_PARITY_EN
            parityNext = evenParity(fifoDout);
`endif
          end else begin
            stateNext = IDLE;
          end
        end else begin
          baudNext = baudCnt + BAUD_W'(1);
        end
      end
      default: begin
        stateNext = IDLE;
        baudNext  = '0;
        bitNext   = 3'd0;
      end
    endcase

    case (stateNext)
      START:   txNext = 1'b0;
      DATA:    txNext = shiftNext[0];
`ifdef UART_TX_PARITY_EN
      PARITY:  txNext = parityNext;
`endif
      default: txNext = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      baudCnt  <= '0;
      bitIdx   <= 3'd0;
      shiftReg <= 8'h00;
      tx       <= 1'b1;
    end else begin
      state    <= stateNext;
      baudCnt  <= baudNext;
      bitIdx   <= bitNext;
      shiftReg <= shiftNext;
      tx       <= txNext;
    end
  end

`ifdef UART_TX_PARITY_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) parityBit <= 1'b0;
    else        parityBit <= parityNext;
  end
`endif

endmodule
